// File: rtl/efuse_macro_model.sv
// Cycle-based stand-in for the 256-bit eFuse macro: holds the fuse array, services read/program strobes, flags errors.
// Optional feature macro: EFUSE_MODEL_TCHK_EN enables strobe width / recovery / stability checks and terr_o.
module efuse_macro_model #(
  parameter logic [255:0] INIT_VAL = '0,
  parameter int unsigned  TRD_MIN  = 2,
  parameter int unsigned  TPGM_MIN = 2,
  parameter int unsigned  TPGM_MAX = 1000,
  parameter int unsigned  TREC     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       efuse_pgmen_i,
  input  logic       efuse_rden_i,
  input  logic       efuse_aen_i,
  input  logic [7:0] efuse_addr_i,
  output logic [7:0] efuse_rdata_o,
  output logic       efuse_terr_o,
  output logic       efuse_merr_o,
  output logic [8:0] efuse_blown_o
);

`ifdef EFUSE_MODEL_TCHK_EN
  localparam bit TCHK_EN = 1'b1;
`else
  localparam bit TCHK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, PG, IGN, REC} state_e;

  // With checks off, recovery collapses to zero cycles: a fall returns straight to IDLE.
  localparam state_e AFTER_FALL = (TCHK_EN && (TREC != 0)) ? REC : IDLE;

  state_e         state_q, state_d;
  logic           aen_q;
  logic [9:0]     cnt_q, cnt_d;
  logic [9:0]     rec_q, rec_d;
  logic [7:0]     addr_q, addr_d;
  logic [255:0]   arr_q, arr_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           terr_q, terr_d;
  logic           merr_q, merr_d;
  logic [8:0]     blown_q, blown_d;

  logic rise, fall, changed, rd_width_ok, pg_width_ok;

  assign rise        = efuse_aen_i & ~aen_q;
  assign fall        = ~efuse_aen_i & aen_q;
  assign changed     = (efuse_addr_i != addr_q) ||
                       (efuse_rden_i != (state_q == RD)) ||
                       (efuse_pgmen_i != (state_q == PG));
  assign rd_width_ok = !TCHK_EN || (cnt_q >= 10'(TRD_MIN));
  assign pg_width_ok = !TCHK_EN || ((cnt_q >= 10'(TPGM_MIN)) && (cnt_q <= 10'(TPGM_MAX)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    addr_d  = addr_q;
    arr_d   = arr_q;
    rdata_d = rdata_q;
    terr_d  = 1'b0;
    merr_d  = 1'b0;
    blown_d = blown_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d  = 10'd1;
          addr_d = efuse_addr_i;
          if (efuse_rden_i && !efuse_pgmen_i) begin
            state_d = RD;
          end else if (efuse_pgmen_i && !efuse_rden_i) begin
            state_d = PG;
          end else begin
            merr_d  = 1'b1;
            state_d = IGN;
          end
        end
      end
      RD, PG: begin
        if (efuse_aen_i) begin
          if (TCHK_EN && changed) begin
            terr_d  = 1'b1;
            state_d = IGN;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 10'd1;
          end
        end else begin
          state_d = AFTER_FALL;
          rec_d   = '0;
          if (state_q == RD) begin
            if (rd_width_ok) rdata_d = arr_q[{addr_q[4:0], 3'b000} +: 8];
            else             terr_d  = 1'b1;
          end else if (pg_width_ok) begin
            arr_d[addr_q] = 1'b1;
            if (!arr_q[addr_q] && (blown_q != 9'd256)) blown_d = blown_q + 9'd1;
          end else begin
            terr_d = 1'b1;
          end
        end
      end
      IGN: begin
        if (fall) begin
          state_d = AFTER_FALL;
          rec_d   = '0;
        end
      end
      REC: begin
        if (rise) begin
          terr_d  = 1'b1;
          state_d = IGN;
        end else if ((rec_q + 10'd1) >= 10'(TREC)) begin
          state_d = IDLE;
        end else begin
          rec_d = rec_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aen_q   <= 1'b0;
      cnt_q   <= '0;
      rec_q   <= '0;
      addr_q  <= '0;
      arr_q   <= INIT_VAL;
      rdata_q <= '0;
      terr_q  <= 1'b0;
      merr_q  <= 1'b0;
      blown_q <= '0;
    end else begin
      state_q <= state_d;
      aen_q   <= efuse_aen_i;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      addr_q  <= addr_d;
      arr_q   <= arr_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
      merr_q  <= merr_d;
      blown_q <= blown_d;
    end
  end

  assign efuse_rdata_o = rdata_q;
  assign efuse_terr_o  = terr_q;
  assign efuse_merr_o  = merr_q;
  assign efuse_blown_o = blown_q;

endmodule
